vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor of the fixed 1440x900 VGA sync generator. Produces the following from one pixel clock:
  - hsync and vsync with selectable polarity;
  - display enable and active-area x/y coordinates;
  - line and frame strobes;
  - a frame counter;
  - a pixel-request strobe issued LEAD cycles early, so a pipelined pixel source lands on de.
- Sits between the pixel clock domain and the framebuffer/sprite pixel pipeline.

Parameters:
- CW, 12: width of internal counters and x/y outputs.
- H_SYNC, 152: hsync width, pixels.
- H_BACK, 232: horizontal back porch.
- H_ACTIVE, 1440: active pixels per line.
- H_FRONT, 80: horizontal front porch.
- V_SYNC, 6: vsync width, lines.
- V_BACK, 25: vertical back porch.
- V_ACTIVE, 900: active lines.
- V_FRONT, 3: vertical front porch.
- H_POL, 1: hsync asserted level (1 = active-high).
- V_POL, 1: vsync asserted level.
- LEAD, 2: req lead in cycles; legal range 0 to H_SYNC+H_BACK-1.
- FW, 16: frame counter width.

Ports:
- pixel_clock, in, 1: pixel clock, all logic on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: 1 = advance timing; 0 = freeze counters and hold all outputs.
- hsync, out, 1: horizontal sync, level per H_POL.
- vsync, out, 1: vertical sync, level per V_POL.
- de, out, 1: display enable (active pixel).
- x, out, CW: active-area column, 0..H_ACTIVE-1; 0 when de=0.
- y, out, CW: active-area row, 0..V_ACTIVE-1; 0 outside active lines.
- req, out, 1: pixel request, leads de by exactly LEAD cycles.
- req_x, out, CW: column the request is for; 0 when req=0.
- line_start, out, 1: one-cycle pulse at h position 0.
- frame_start, out, 1: one-cycle pulse at h=0, v=0.
- frame_count, out, FW: completed-frame counter.

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise.
  - Exactly H_TOTAL clocks per line and V_TOTAL lines per frame; no extra wrap cycle.
- Region order per axis: sync, back porch, active, front porch.
  - HA0 = H_SYNC+H_BACK; HA1 = HA0+H_ACTIVE.
  - VA0 and VA1 are defined the same way for the vertical axis.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1):
  - h_cnt wraps to 0 after H_TOTAL-1.
  - v_cnt advances only on that wrap cycle and wraps to 0 after V_TOTAL-1.
- Output decode, on every enabled edge, from the current (h_cnt, v_cnt), before the counters advance. All outputs are registered with one cycle latency after the count they describe.
  - hsync asserted when h_cnt < H_SYNC.
  - vsync asserted when v_cnt < V_SYNC. Changes only when h_cnt=0, coincident with the hsync leading edge.
  - de = (HA0 <= h_cnt < HA1) and (VA0 <= v_cnt < VA1).
  - x = h_cnt-HA0 when de, else 0.
  - y = v_cnt-VA0 inside active lines, else 0.
  - req = active line and (HA0-LEAD <= h_cnt < HA1-LEAD); req_x = h_cnt+LEAD-HA0 when req, else 0.
  - LEAD=0 makes req identical to de.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 and v_cnt==0).
- frame_count increments, modulo 2^FW, on the edge that registers frame_start=1.
  - The first frame after reset shows frame_count=1 coincident with the first frame_start.
- Reset, asynchronous and at any point mid-frame:
  - Counters go to 0 and frame_count to 0.
  - de, req, line_start, frame_start go to 0; x, y, req_x go to 0.
  - hsync goes to ~H_POL and vsync to ~V_POL (deasserted).
- First enabled edge after reset release registers the decode of (0,0): hsync and vsync asserted, line_start=1, frame_start=1.
- enable=0: no counter, output, or frame_count change. Pulses high at the time of freeze stay high until enable returns; the bench must gate pulses with enable.
- Elaboration checks: LEAD < HA0; H_TOTAL < 2^CW; V_TOTAL < 2^CW. On failure, halt elaboration with an error.

Decomposition:
- Package vga_timing_pkg:
  - Default mode constants: 1440x900 and 640x480@60 (sync 96/48/640/16, v 2/33/480/10).
  - Total and active-start helper functions.
  - Polarity constants.
- Sub-module vga_axis_counter, instantiated for h and v:
  - Parameters: one axis (sync/back/active/front).
  - Inputs: step/advance.
  - Outputs: count, wrap flag, in_sync, in_active, active_index.
- The top adds the req lead window, registers, strobes and the frame counter.

Test Plan:
Small bench config: H 2/3/8/1 (H_TOTAL 14); V 1/2/4/1 (V_TOTAL 8); LEAD=2; polarities 1.
- Reset release, enable=1:
  - Edge 1: hsync=1, vsync=1, frame_start=1, frame_count=1.
  - hsync high exactly 2 cycles per 14.
  - vsync high exactly 14 cycles per 112.
- Line 3 (first active line): de high 8 consecutive cycles, x = 0..7; y=0.
  - req rises 2 cycles before de, with req_x = 0..7, and falls 2 cycles before de falls.
  - Line 6: y=3. Line 7: de never asserts.
- Run 3 frames: frame_start period exactly 112 cycles; frame_count = 1, 2, 3; line_start period 14.
- enable low for 5 cycles mid-active (x=4): all outputs hold; on re-enable x continues at 5 with no skipped or duplicated pixels.
- Assert reset at x=6 of line 4: all outputs go to reset values immediately, without waiting for a clock edge; after release, the sequence restarts from frame_start with frame_count=1.
- H_POL=0, V_POL=0, LEAD=0: sync outputs inverted; req == de every cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA sync generator and its axis counters.
package vga_timing_pkg;

  localparam bit POL_HIGH = 1'b1;
  localparam bit POL_LOW  = 1'b0;

  // 1440x900 mode
  localparam int M1440_H_SYNC   = 152;
  localparam int M1440_H_BACK   = 232;
  localparam int M1440_H_ACTIVE = 1440;
  localparam int M1440_H_FRONT  = 80;
  localparam int M1440_V_SYNC   = 6;
  localparam int M1440_V_BACK   = 25;
  localparam int M1440_V_ACTIVE = 900;
  localparam int M1440_V_FRONT  = 3;

  // 640x480@60 mode
  localparam int M640_H_SYNC    = 96;
  localparam int M640_H_BACK    = 48;
  localparam int M640_H_ACTIVE  = 640;
  localparam int M640_H_FRONT   = 16;
  localparam int M640_V_SYNC    = 2;
  localparam int M640_V_BACK    = 33;
  localparam int M640_V_ACTIVE  = 480;
  localparam int M640_V_FRONT   = 10;

  function automatic int axis_total(input int sync, input int back, input int active,
                                    input int front);
    return sync + back + active + front;
  endfunction

  function automatic int active_start(input int sync, input int back);
    return sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: free-running position counter with region decode for sync and active.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW     = 12,
  parameter int SYNC   = 2,
  parameter int BACK   = 3,
  parameter int ACTIVE = 8,
  parameter int FRONT  = 1
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_active,
  output logic [CW-1:0] active_index
);

  localparam logic [CW-1:0] LAST     = CW'(axis_total(SYNC, BACK, ACTIVE, FRONT) - 1);
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
  localparam logic [CW-1:0] ACT_BEG  = CW'(active_start(SYNC, BACK));
  localparam logic [CW-1:0] ACT_END  = CW'(active_start(SYNC, BACK) + ACTIVE);

  assign wrap         = (count == LAST);
  assign in_sync      = (count < SYNC_END);
  assign in_active    = (count >= ACT_BEG) && (count < ACT_END);
  assign active_index = count - ACT_BEG;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: syncs, display enable, coordinates, early pixel request,
// line/frame strobes and a frame counter, all registered one cycle after the count they decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = 12,
  parameter int H_SYNC   = M1440_H_SYNC,
  parameter int H_BACK   = M1440_H_BACK,
  parameter int H_ACTIVE = M1440_H_ACTIVE,
  parameter int H_FRONT  = M1440_H_FRONT,
  parameter int V_SYNC   = M1440_V_SYNC,
  parameter int V_BACK   = M1440_V_BACK,
  parameter int V_ACTIVE = M1440_V_ACTIVE,
  parameter int V_FRONT  = M1440_V_FRONT,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int LEAD     = 2,
  parameter int FW       = 16
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HA0     = active_start(H_SYNC, H_BACK);
  localparam int HA1     = HA0 + H_ACTIVE;

  if (LEAD < 0 || LEAD >= HA0) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must lie in 0..H_SYNC+H_BACK-1");
  end
  if (H_TOTAL >= (1 << CW)) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  localparam logic [CW-1:0] REQ_BEG = CW'(HA0 - LEAD);
  localparam logic [CW-1:0] REQ_END = CW'(HA1 - LEAD);
  localparam logic [CW-1:0] LEAD_C  = CW'(LEAD);
  localparam logic [CW-1:0] HA0_C   = CW'(HA0);
  localparam logic          HS_ON   = 1'(H_POL);
  localparam logic          VS_ON   = 1'(V_POL);

  logic [CW-1:0] h_cnt, v_cnt, h_idx, v_idx;
  logic          h_wrap, h_sync_p0, h_act_p0;
  logic          v_sync_p0, v_act_p0;
  // The frame boundary is taken from v_cnt == 0, so the vertical wrap flag is not needed.
  logic          v_wrap_unused;

  vga_axis_counter #(
    .CW(CW), .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
  ) u_h_axis (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .step        (enable),
    .count       (h_cnt),
    .wrap        (h_wrap),
    .in_sync     (h_sync_p0),
    .in_active   (h_act_p0),
    .active_index(h_idx)
  );

  vga_axis_counter #(
    .CW(CW), .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
  ) u_v_axis (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .step        (enable & h_wrap),
    .count       (v_cnt),
    .wrap        (v_wrap_unused),
    .in_sync     (v_sync_p0),
    .in_active   (v_act_p0),
    .active_index(v_idx)
  );

  logic          de_p0, req_p0, line_start_p0, frame_start_p0;
  logic [CW-1:0] req_x_p0;

  always_comb begin
    de_p0          = h_act_p0 && v_act_p0;
    req_p0         = v_act_p0 && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);
    req_x_p0       = req_p0 ? (h_cnt + LEAD_C - HA0_C) : '0;
    line_start_p0  = (h_cnt == '0);
    frame_start_p0 = line_start_p0 && (v_cnt == '0);
  end

  // ---- stage p0 -> p1: registered outputs ----
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      req         <= 1'b0;
      req_x       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      hsync       <= h_sync_p0 ? HS_ON : ~HS_ON;
      vsync       <= v_sync_p0 ? VS_ON : ~VS_ON;
      de          <= de_p0;
      x           <= de_p0 ? h_idx : '0;
      y           <= v_act_p0 ? v_idx : '0;
      req         <= req_p0;
      req_x       <= req_x_p0;
      line_start  <= line_start_p0;
      frame_start <= frame_start_p0;
      if (frame_start_p0) begin
        frame_count <= frame_count + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 14x8 raster, two polarity/lead configurations.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        hs, vs, de;
    logic [11:0] x, y;
    logic        req;
    logic [11:0] rx;
    logic        ls, fs;
    logic [15:0] fc;
  } half_t;

  typedef struct packed {
    half_t a;
    half_t b;
  } obs_t;

  logic pixel_clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic        hsync, vsync, de, req, line_start, frame_start;
  logic [11:0] x, y, req_x;
  logic [15:0] frame_count;
  logic        hsync2, vsync2, de2, req2, line_start2, frame_start2;
  logic [11:0] x2, y2, req_x2;
  logic [15:0] frame_count2;

  vga_timing_gen #(
    .CW(12), .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .H_POL(1), .V_POL(1), .LEAD(2), .FW(16)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .req(req), .req_x(req_x), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .CW(12), .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .H_POL(0), .V_POL(0), .LEAD(0), .FW(16)
  ) dut_inv (
    .pixel_clock(pixel_clock), .reset(reset), .enable(enable),
    .hsync(hsync2), .vsync(vsync2), .de(de2), .x(x2), .y(y2),
    .req(req2), .req_x(req_x2), .line_start(line_start2),
    .frame_start(frame_start2), .frame_count(frame_count2)
  );

  always #5 pixel_clock = ~pixel_clock;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t last;
  obs_t rst_obs;
  int   pos = 0;
  int   frames = 0;

  bit   agg_on = 1'b0;
  int   samp_idx = 0;
  int   hs_n = 0, vs_n = 0, ls_n = 0, fs_n = 0, fs_prev = -1;

  // Reference raster: position p within a frame, region boundaries from the small config.
  function automatic half_t model(input int p, input int lead, input bit hp, input bit vp,
                                  input int f);
    half_t m;
    int h, v;
    bit act;
    h      = p % HT;
    v      = p / HT;
    act    = (v >= 3) && (v < 7);
    m      = '0;
    m.hs   = (h < 2) ? hp : !hp;
    m.vs   = (v < 1) ? vp : !vp;
    m.de   = act && (h >= 5) && (h < 13);
    m.x    = m.de ? 12'(h - 5) : 12'd0;
    m.y    = act ? 12'(v - 3) : 12'd0;
    m.req  = act && (h >= 5 - lead) && (h < 13 - lead);
    m.rx   = m.req ? 12'(h + lead - 5) : 12'd0;
    m.ls   = (h == 0);
    m.fs   = (p == 0);
    m.fc   = 16'(f);
    return m;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.a = '{hsync, vsync, de, x, y, req, req_x, line_start, frame_start, frame_count};
    o.b = '{hsync2, vsync2, de2, x2, y2, req2, req_x2, line_start2, frame_start2, frame_count2};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the outputs expected after the next rise.
  task automatic cycle(input bit en, input bit rs);
    @(negedge pixel_clock);
    if (agg_on) begin
      if (hsync) hs_n++;
      if (vsync) vs_n++;
      if (line_start) ls_n++;
      if (frame_start) begin
        fs_n++;
        check_int("frame_count_seq", int'(frame_count), fs_n);
        if (fs_prev >= 0) check_int("frame_period", samp_idx - fs_prev, FT);
        fs_prev = samp_idx;
      end
      samp_idx++;
    end
    enable = en;
    if (rs && !reset) begin
      reset = 1'b1;
      #1;
      check_obs("async_reset", actual(), rst_obs);
    end
    reset = rs;
    if (rs) begin
      pos    = 0;
      frames = 0;
      last   = rst_obs;
    end else if (en) begin
      if (pos == 0) frames++;
      last.a = model(pos, 2, 1'b1, 1'b1, frames);
      last.b = model(pos, 0, 1'b0, 1'b0, frames);
      pos    = (pos + 1) % FT;
    end
    exp_q.push_back(last);
  endtask

  initial begin
    forever begin
      @(posedge pixel_clock);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check_obs("cycle", actual(), e);
      end
    end
  end

  initial begin
    bit found;
    rst_obs   = '0;
    rst_obs.b.hs = 1'b1;
    rst_obs.b.vs = 1'b1;
    last      = rst_obs;

    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);

    agg_on = 1'b1;
    repeat (FT * 3) cycle(1'b1, 1'b0);
    agg_on = 1'b0;
    check_int("hsync_cycles_3f", hs_n, 3 * 2 * VT);
    check_int("vsync_cycles_3f", vs_n, 3 * HT);
    check_int("line_starts_3f", ls_n, 3 * VT);
    check_int("frame_starts_3f", fs_n, 3);

    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      cycle(1'b1, 1'b0);
      if (last.a.de && last.a.x == 12'd4) found = 1'b1;
    end
    check_int("freeze_point_reached", int'(found), 1);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      cycle(1'b1, 1'b0);
      if (last.a.de && last.a.y == 12'd1 && last.a.x == 12'd6) found = 1'b1;
    end
    check_int("reset_point_reached", int'(found), 1);
    repeat (3) cycle(1'b1, 1'b1);
    repeat (FT + 20) cycle(1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 399) == 0);
    end
    cycle(1'b1, 1'b0);

    repeat (3) @(negedge pixel_clock);
    check_int("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
